// File: rtl/shift_sequencer.sv
// shift_sequencer: multicycle sequencer for the shift register and its ALUOut
// write-back. It handles sll/srl/sra, sllv/srlv/srav and lui. Each operation
// loads the operand, issues one or more shifts, then writes the result.
// It talks to the main control unit through a start/busy/done handshake.
module shift_sequencer #(
    parameter int STEP_MODE = 0,   // 0: one full-amount shift; 1: amt single-bit shifts
    parameter int LUI_AMT   = 16
) (
    input  logic        clk,
    input  logic        reset,          // asynchronous, active-low
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [4:0]  shamt_imm,
    input  logic [31:0] shamt_reg,
    input  logic        flush,
    output logic [2:0]  shifter_ctrl,
    output logic [4:0]  shifter_n,
    output logic        m_shifter,
    output logic [1:0]  m_aluout_sel,
    output logic        aluout_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_SLLV = 3'b011;
    localparam logic [2:0] OP_SRLV = 3'b100;
    localparam logic [2:0] OP_SRAV = 3'b101;
    localparam logic [2:0] OP_LUI  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [2:0] CTRL_NOP  = 3'b000;
    localparam logic [2:0] CTRL_LOAD = 3'b001;
    localparam logic [2:0] CTRL_SLL  = 3'b010;
    localparam logic [2:0] CTRL_SRL  = 3'b011;
    localparam logic [2:0] CTRL_SRA  = 3'b100;

    localparam logic [4:0] LUI_N = LUI_AMT[4:0];

    logic [2:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [4:0] amt_q, amt_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] amt_sel;
    logic [2:0] dir_ctrl;

    // Only the low five bits of rs form a shift amount.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^shamt_reg[31:5];

    // Shift amount source chosen by the incoming opcode.
    always_comb begin
        case (op)
            OP_SLL, OP_SRL, OP_SRA:    amt_sel = shamt_imm;
            OP_SLLV, OP_SRLV, OP_SRAV: amt_sel = shamt_reg[4:0];
            OP_LUI:                    amt_sel = LUI_N;
            default:                   amt_sel = 5'd0;
        endcase
    end

    // Shifter direction for the latched opcode (LUI is a left shift).
    always_comb begin
        case (op_q)
            OP_SRL, OP_SRLV: dir_ctrl = CTRL_SRL;
            OP_SRA, OP_SRAV: dir_ctrl = CTRL_SRA;
            default:         dir_ctrl = CTRL_SLL;
        endcase
    end

    // Next-state logic; flush overrides everything, including a start in IDLE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d    = op;
                        amt_d   = amt_sel;
                        state_d = (op == OP_ILL) ? S_ERR : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (amt_q == 5'd0) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_SHIFT;
                        cnt_d   = amt_q;
                    end
                end
                S_SHIFT: begin
                    cnt_d = cnt_q - 5'd1;
                    if (STEP_MODE == 0 || cnt_q <= 5'd1) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and operand registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            amt_q   <= 5'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        shifter_ctrl = CTRL_NOP;
        shifter_n    = 5'd0;
        m_shifter    = 1'b0;
        m_aluout_sel = 2'b00;
        aluout_we    = 1'b0;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        err          = 1'b0;
        case (state_q)
            S_LOAD: begin
                shifter_ctrl = CTRL_LOAD;
                m_shifter    = (op_q == OP_LUI);
            end
            S_SHIFT: begin
                shifter_ctrl = dir_ctrl;
                shifter_n    = (STEP_MODE != 0) ? 5'd1 : amt_q;
                m_shifter    = (op_q == OP_LUI);
            end
            S_WRITE: begin
                m_aluout_sel = 2'b10;
                aluout_we    = 1'b1;
                done         = 1'b1;
            end
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer: one instance per STEP_MODE shares the
// same stimulus; each cycle's outputs are checked against a cycle-timeline model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [4:0]  shamt_imm = 5'd0;
    logic [31:0] shamt_reg = 32'd0;
    logic        flush = 1'b0;

    logic [2:0] ctrl0, ctrl1;
    logic [4:0] n0, n1;
    logic       msh0, msh1;
    logic [1:0] sel0, sel1;
    logic       we0, we1, busy0, busy1, done0, done1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.STEP_MODE(0), .LUI_AMT(16)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .shamt_imm(shamt_imm),
        .shamt_reg(shamt_reg), .flush(flush), .shifter_ctrl(ctrl0), .shifter_n(n0),
        .m_shifter(msh0), .m_aluout_sel(sel0), .aluout_we(we0), .busy(busy0),
        .done(done0), .err(err0));

    shift_sequencer #(.STEP_MODE(1), .LUI_AMT(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .shamt_imm(shamt_imm),
        .shamt_reg(shamt_reg), .flush(flush), .shifter_ctrl(ctrl1), .shifter_n(n1),
        .m_shifter(msh1), .m_aluout_sel(sel1), .aluout_we(we1), .busy(busy1),
        .done(done1), .err(err1));

    // Packed view: {busy, done, err, we, sel[1:0], m_shifter, ctrl[2:0], n[4:0]}
    logic [14:0] obs0, obs1;
    assign obs0 = {busy0, done0, err0, we0, sel0, msh0, ctrl0, n0};
    assign obs1 = {busy1, done1, err1, we1, sel1, msh1, ctrl1, n1};

    task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int amt_of(input logic [2:0] o, input logic [4:0] imm, input logic [31:0] rv);
        if (o <= 3'd2) return int'(imm);
        if (o <= 3'd5) return int'(rv % 32);
        if (o == 3'd6) return 16;
        return 0;
    endfunction

    // Expected outputs k cycles after the accepting edge, from the operation timeline:
    // cycle 1 loads, then the shift phase, then one write/done cycle, then idle.
    function automatic logic [14:0] model(input int mode, input logic [2:0] o, input int amt, input int k);
        int s;
        logic lui;
        logic [2:0] dir;
        logic [4:0] nv;
        if (o == 3'd7) return (k == 1) ? 15'b111_0_00_0_000_00000 : 15'd0;
        lui = (o == 3'd6);
        if (o == 3'd1 || o == 3'd4) dir = 3'b011;
        else if (o == 3'd2 || o == 3'd5) dir = 3'b100;
        else dir = 3'b010;
        if (amt == 0) s = 0;
        else if (mode != 0) s = amt;
        else s = 1;
        nv = (mode != 0) ? 5'd1 : 5'(amt);
        if (k == 1) return {1'b1, 3'b000, 2'b00, lui, 3'b001, 5'd0};
        if (k >= 2 && k <= 1 + s) return {1'b1, 3'b000, 2'b00, lui, dir, nv};
        if (k == 2 + s) return 15'b110_1_10_0_000_00000;
        return 15'd0;
    endfunction

    // One transaction; start stays high one extra cycle with different operands,
    // which the busy sequencer must ignore.
    task automatic run_txn(input logic [2:0] o, input logic [4:0] imm, input logic [31:0] rv, input string tag);
        int amt;
        int len;
        amt = amt_of(o, imm, rv);
        len = amt + 4;
        @(negedge clk);
        op = o; shamt_imm = imm; shamt_reg = rv; start = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s_op%0d_m0_k%0d", tag, o, k), obs0, model(0, o, amt, k));
            check_eq($sformatf("%s_op%0d_m1_k%0d", tag, o, k), obs1, model(1, o, amt, k));
            if (k == 1) begin
                op = ~o; shamt_imm = ~imm; shamt_reg = ~rv;
            end
            if (k == 2) start = 1'b0;
        end
    endtask

    initial begin
        // Reset state, including asynchronous assertion
        #2 reset = 1'b0;
        #1;
        check_eq("reset_m0", obs0, 15'd0);
        check_eq("reset_m1", obs1, 15'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle_m0", obs0, 15'd0);
        check_eq("idle_m1", obs1, 15'd0);

        // Directed cases
        run_txn(3'b000, 5'd4, 32'd0, "sll4");
        run_txn(3'b101, 5'd0, 32'h0000_0025, "srav25");
        run_txn(3'b101, 5'd0, 32'h0000_0020, "srav20");
        run_txn(3'b011, 5'd0, 32'h0000_0021, "sllv21");
        run_txn(3'b110, 5'd0, 32'd0, "lui");
        run_txn(3'b111, 5'd3, 32'd0, "ill");
        run_txn(3'b001, 5'd31, 32'd0, "srl31");

        // Flush during SHIFT: no write, no done, idle next cycle
        @(negedge clk);
        op = 3'b000; shamt_imm = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("flush_pre_m0", obs0, model(0, 3'b000, 4, 2));
        check_eq("flush_pre_m1", obs1, model(1, 3'b000, 4, 2));
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_m0", obs0, 15'd0);
        check_eq("flush_m1", obs1, 15'd0);
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_after_m0", obs0, 15'd0);
        check_eq("flush_after_m1", obs1, 15'd0);

        // Flush wins over start in IDLE
        start = 1'b1; flush = 1'b1; op = 3'b001; shamt_imm = 5'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_eq("flush_start_m0", obs0, 15'd0);
        check_eq("flush_start_m1", obs1, 15'd0);
        @(negedge clk);
        check_eq("flush_start2_m0", obs0, 15'd0);
        check_eq("flush_start2_m1", obs1, 15'd0);

        // Reset during LOAD clears outputs without a clock edge
        op = 3'b110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("rst_load_m0", obs0, model(0, 3'b110, 16, 1));
        check_eq("rst_load_m1", obs1, model(1, 3'b110, 16, 1));
        #2 reset = 1'b0;
        #1;
        check_eq("rst_async_m0", obs0, 15'd0);
        check_eq("rst_async_m1", obs1, 15'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_idle_m0", obs0, 15'd0);
        check_eq("rst_idle_m1", obs1, 15'd0);

        // start held high re-triggers on the first IDLE cycle after done
        op = 3'b000; shamt_imm = 5'd2; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                int d;
                int ke;
                d = (m != 0) ? 4 : 3;
                ke = (k <= d + 1) ? k : k - (d + 1);
                check_eq($sformatf("retrig_m%0d_k%0d", m, k), (m != 0) ? obs1 : obs0,
                         model(m, 3'b000, 2, ke));
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("retrig_drain_m0", obs0, 15'd0);
        check_eq("retrig_drain_m1", obs1, 15'd0);

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            logic [2:0] ro;
            logic [4:0] ri;
            logic [31:0] rr;
            ro = 3'($urandom_range(0, 7));
            ri = 5'($urandom);
            rr = $urandom;
            run_txn(ro, ri, rr, $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
